// File: rtl/time_set_ctrl.sv
// Button front-end and set-mode FSM for the hh:mm:ss counter: synchronise, debounce, edit shadow time, load.
// Optional macro HOLD_REPEAT_EN adds auto-repeat while the inc button is held in an edit state.
module time_set_ctrl #(
    parameter int DEB_CNT      = 4,
    parameter int HOUR_MAX     = 23,
    parameter int REPEAT_TICKS = 8
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       tick_en,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [5:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       load_time,
    output logic       run_en,
    output logic [1:0] field_sel
);

    localparam logic [3:0] DEB_LAST = 4'(DEB_CNT - 1);
    localparam logic [5:0] HOUR_LIM = 6'(HOUR_MAX);
    localparam logic [5:0] MS_LIM   = 6'd59;

    typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, COMMIT} state_t;

    logic [1:0] raw;
    logic [1:0] press;
    logic       mode_evt;
    logic       inc_evt;

    assign raw = {btn_inc, btn_mode};

    // Index 0 is the mode button, index 1 the increment button.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_btn
            logic       sync1_reg;
            logic       sync2_reg;
            logic       level_reg;
            logic       press_reg;
            logic [3:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (RESET) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= 4'd0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (tick_en) begin
                        if (sync2_reg == level_reg) begin
                            cnt_reg <= 4'd0;
                        end else if (cnt_reg == DEB_LAST) begin
                            cnt_reg   <= 4'd0;
                            level_reg <= sync2_reg;
                            press_reg <= sync2_reg;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    state_t state_reg;

    assign mode_evt = press[0];

`ifdef HOLD_REPEAT_EN
    localparam int             HW      = $clog2(REPEAT_TICKS + 1);
    localparam logic [HW-1:0]  REP_LIM = HW'(REPEAT_TICKS);

    logic          inc_level;
    logic          editing;
    logic [HW-1:0] hold_cnt_reg;
    logic          phase_reg;
    logic          rep_reg;

    assign inc_level = gen_btn[1].level_reg;
    assign editing   = (state_reg == SET_H) || (state_reg == SET_M) || (state_reg == SET_S);

    // After REPEAT_TICKS of hold, emit one repeat every second tick.
    always_ff @(posedge clk) begin
        if (RESET || !editing || !inc_level || mode_evt) begin
            hold_cnt_reg <= '0;
            phase_reg    <= 1'b0;
            rep_reg      <= 1'b0;
        end else begin
            rep_reg <= 1'b0;
            if (tick_en) begin
                if (hold_cnt_reg < REP_LIM) begin
                    hold_cnt_reg <= hold_cnt_reg + 1'b1;
                end else begin
                    phase_reg <= ~phase_reg;
                    rep_reg   <= phase_reg;
                end
            end
        end
    end

    assign inc_evt = press[1] | rep_reg;
`else
    assign inc_evt = press[1];
`endif

    logic [5:0] set_hour_reg;
    logic [5:0] set_min_reg;
    logic [5:0] set_sec_reg;
    logic       load_time_reg;
    logic       run_en_reg;
    logic [1:0] field_sel_reg;

    // Mode is checked before inc in every state, so a coincident inc is dropped.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_reg     <= RUN;
            set_hour_reg  <= 6'd0;
            set_min_reg   <= 6'd0;
            set_sec_reg   <= 6'd0;
            load_time_reg <= 1'b0;
            run_en_reg    <= 1'b1;
            field_sel_reg <= 2'd0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (mode_evt) begin
                        state_reg     <= SET_H;
                        set_hour_reg  <= cur_hour;
                        set_min_reg   <= cur_min;
                        set_sec_reg   <= cur_sec;
                        run_en_reg    <= 1'b0;
                        field_sel_reg <= 2'd1;
                    end
                end
                SET_H: begin
                    if (mode_evt) begin
                        state_reg     <= SET_M;
                        field_sel_reg <= 2'd2;
                    end else if (inc_evt) begin
                        set_hour_reg <= (set_hour_reg >= HOUR_LIM) ? 6'd0 : set_hour_reg + 6'd1;
                    end
                end
                SET_M: begin
                    if (mode_evt) begin
                        state_reg     <= SET_S;
                        field_sel_reg <= 2'd3;
                    end else if (inc_evt) begin
                        set_min_reg <= (set_min_reg >= MS_LIM) ? 6'd0 : set_min_reg + 6'd1;
                    end
                end
                SET_S: begin
                    if (mode_evt) begin
                        state_reg     <= COMMIT;
                        load_time_reg <= 1'b1;
                        field_sel_reg <= 2'd0;
                    end else if (inc_evt) begin
                        set_sec_reg <= (set_sec_reg >= MS_LIM) ? 6'd0 : set_sec_reg + 6'd1;
                    end
                end
                COMMIT: begin
                    state_reg     <= RUN;
                    load_time_reg <= 1'b0;
                    run_en_reg    <= 1'b1;
                end
                default: begin
                    state_reg     <= RUN;
                    load_time_reg <= 1'b0;
                    run_en_reg    <= 1'b1;
                    field_sel_reg <= 2'd0;
                end
            endcase
        end
    end

    assign set_hour  = set_hour_reg;
    assign set_min   = set_min_reg;
    assign set_sec   = set_sec_reg;
    assign load_time = load_time_reg;
    assign run_en    = run_en_reg;
    assign field_sel = field_sel_reg;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomised bench for time_set_ctrl: button presses are modelled as whole events against a
// field/value reference model; load pulses are recorded by a monitor and compared to the model.
module tb_time_set_ctrl;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       tick_en = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] cur_hour = 6'd0;
    logic [5:0] cur_min = 6'd0;
    logic [5:0] cur_sec = 6'd0;
    logic [5:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       load_time;
    logic       run_en;
    logic [1:0] field_sel;

    time_set_ctrl dut (
        .clk       (clk),
        .RESET     (RESET),
        .tick_en   (tick_en),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .load_time (load_time),
        .run_en    (run_en),
        .field_sel (field_sel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Load pulse monitor
    int load_cnt = 0;
    int ld_h, ld_m, ld_s;
    always @(negedge clk) begin
        if (load_time) begin
            load_cnt = load_cnt + 1;
            ld_h = set_hour;
            ld_m = set_min;
            ld_s = set_sec;
            $display("load pulse #%0d: %0d:%0d:%0d", load_cnt, ld_h, ld_m, ld_s);
        end
    end

    // Reference model: field being edited (0 none) and shadow values
    int m_field = 0;
    int m_h = 0, m_m = 0, m_s = 0;
    int m_loads = 0;
    int m_ld_h = 0, m_ld_m = 0, m_ld_s = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int step(input int v, input int lim);
        return (v >= lim) ? 0 : v + 1;
    endfunction

    function automatic void model_press(input bit mode, input bit inc);
        if (mode) begin
            case (m_field)
                0: begin
                    m_h = cur_hour; m_m = cur_min; m_s = cur_sec;
                    m_field = 1;
                end
                1, 2: m_field = m_field + 1;
                default: begin
                    m_loads++;
                    m_ld_h = m_h; m_ld_m = m_m; m_ld_s = m_s;
                    m_field = 0;
                end
            endcase
        end else if (inc) begin
            case (m_field)
                1: m_h = step(m_h, 23);
                2: m_m = step(m_m, 59);
                3: m_s = step(m_s, 59);
                default: ;
            endcase
        end
    endfunction

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) @(negedge clk);
            tick_en = 1'b1;
            @(negedge clk);
            tick_en = 1'b0;
        end
    endtask

    task automatic press(input bit mode, input bit inc);
        btn_mode = mode;
        btn_inc  = inc;
        tick_n(DEB);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick_n(DEB);
        repeat (2) @(negedge clk);
        model_press(mode, inc);
        $display("press mode=%0b inc=%0b -> field=%0d set=%0d:%0d:%0d run_en=%0b loads=%0d",
                 mode, inc, field_sel, set_hour, set_min, set_sec, run_en, load_cnt);
    endtask

    task automatic verify(input string tag);
        check({tag, ".field"}, field_sel, m_field);
        check({tag, ".run_en"}, run_en, (m_field == 0) ? 1 : 0);
        check({tag, ".hour"}, set_hour, m_h);
        check({tag, ".min"}, set_min, m_m);
        check({tag, ".sec"}, set_sec, m_s);
        check({tag, ".loads"}, load_cnt, m_loads);
        if (m_loads > 0) begin
            check({tag, ".ld_h"}, ld_h, m_ld_h);
            check({tag, ".ld_m"}, ld_m, m_ld_m);
            check({tag, ".ld_s"}, ld_s, m_ld_s);
        end
    endtask

    initial begin
        int loads_before;

        // Reset
        repeat (3) @(negedge clk);
        RESET = 1'b0;
        @(negedge clk);
        check("rst.run_en", run_en, 1);
        check("rst.load", load_time, 0);
        check("rst.field", field_sel, 0);
        check("rst.hour", set_hour, 0);
        check("rst.min", set_min, 0);
        check("rst.sec", set_sec, 0);

        // Enter edit from 12:34:56
        cur_hour = 6'd12; cur_min = 6'd34; cur_sec = 6'd56;
        press(1'b1, 1'b0);
        verify("enter");

        // Chatter 1,0,1,0 then steady high: single inc only after 4th stable sample
        btn_inc = 1'b1; tick_n(1);
        btn_inc = 1'b0; tick_n(1);
        btn_inc = 1'b1; tick_n(1);
        btn_inc = 1'b0; tick_n(1);
        btn_inc = 1'b1; tick_n(3);
        repeat (2) @(negedge clk);
        check("chatter.none", set_hour, 12);
        tick_n(1);
        repeat (2) @(negedge clk);
        check("chatter.one", set_hour, 13);
        btn_inc = 1'b0; tick_n(DEB);
        repeat (2) @(negedge clk);
        check("chatter.release", set_hour, 13);
        model_press(1'b0, 1'b1);

        press(1'b0, 1'b1);
        verify("inc14");
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        verify("commit1");

        // Wrap cases
        cur_hour = 6'd23; cur_min = 6'd59; cur_sec = 6'd59;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        verify("wrap_h");
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        verify("wrap_m");
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        verify("wrap_s");
        press(1'b1, 1'b0);
        verify("commit2");

        // Simultaneous mode+inc in SET_M
        cur_hour = 6'd5; cur_min = 6'd17; cur_sec = 6'd40;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        verify("simul");
        check("simul.min_kept", set_min, 17);

        // Reset while in SET_S: no load, outputs back to idle
        loads_before = load_cnt;
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        check("midrst.run_en", run_en, 1);
        check("midrst.field", field_sel, 0);
        check("midrst.load", load_time, 0);
        check("midrst.hour", set_hour, 0);
        check("midrst.min", set_min, 0);
        check("midrst.sec", set_sec, 0);
        repeat (4) @(negedge clk);
        check("midrst.no_load", load_cnt, loads_before);
        m_field = 0; m_h = 0; m_m = 0; m_s = 0;

        // Random press sequence, including captured values above field limits
        for (int i = 0; i < 60; i++) begin
            bit do_mode;
            bit do_inc;
            do_mode = ($urandom_range(0, 9) < 4);
            do_inc  = !do_mode || ($urandom_range(0, 9) == 0);
            if (m_field == 0) begin
                cur_hour = 6'($urandom_range(0, 63));
                cur_min  = 6'($urandom_range(0, 63));
                cur_sec  = 6'($urandom_range(0, 63));
            end
            press(do_mode, do_inc);
            verify("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
